// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: serialises parallel words onto a one-bit shift datapath.
// A word is accepted over valid/ready in IDLE and presented one bit per clock.
// A shift strobe and frame start/done pulses accompany the bits, and an idle
// gap of GAP_CYCLES follows each frame. hold freezes the current bit.
// Optional build macro: SHIFT_SEQ_PARITY_EN appends an even-parity bit to each frame.
module shift_seq_ctrl #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1,
    parameter int MSB_FIRST  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    input  logic                          hold,
    output logic                          serial_out,
    output logic                          shift_en,
    output logic                          frame_start,
    output logic                          frame_done,
    output logic                          busy,
    output logic [$clog2(DATA_W+1)-1:0]   bit_idx
);

    localparam int IDX_W    = $clog2(DATA_W + 1);
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
    localparam int GAP_W    = (GAP_LOAD > 0) ? $clog2(GAP_LOAD + 1) : 1;

`ifdef SHIFT_SEQ_PARITY_EN
    // The parity bit occupies index DATA_W, one past the last data bit.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

`ifdef SHIFT_SEQ_PARITY_EN
    // Even parity: XOR of all bits of the word.
    function automatic logic even_parity(input logic [DATA_W-1:0] w);
        return ^w;
    endfunction
`endif

    // Bit presented at frame index k for word w, honouring the configured bit order.
    function automatic logic pick_bit(input logic [DATA_W-1:0] w, input logic [IDX_W-1:0] k);
        logic [DATA_W-1:0] t;
        if (MSB_FIRST != 0) begin
            t = w >> (IDX_W'(DATA_W - 1) - k);
        end else begin
            t = w >> k;
        end
`ifdef SHIFT_SEQ_PARITY_EN
        if (k == LAST_IDX) begin
            t[0] = even_parity(w);
        end else begin
            t[0] = t[0];
        end
`endif
        return t[0];
    endfunction

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              ready_q, ready_d;
    logic              serial_q, serial_d;
    logic              shift_en_q, shift_en_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    // Next-state and next-output computation for the IDLE/SHIFT/GAP sequencer.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        ready_d    = ready_q;
        serial_d   = serial_q;
        shift_en_d = 1'b0;
        start_d    = 1'b0;
        done_d     = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                serial_d = 1'b0;
                idx_d    = {IDX_W{1'b0}};
                if (in_valid) begin
                    shadow_d   = in_data;
                    state_d    = ST_SHIFT;
                    serial_d   = pick_bit(in_data, {IDX_W{1'b0}});
                    shift_en_d = 1'b1;
                    start_d    = 1'b1;
                    busy_d     = 1'b1;
                    ready_d    = 1'b0;
                end else begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (hold) begin
                    // Freeze: bit and index stay, no strobe, no repeated pulses.
                    serial_d = serial_q;
                    idx_d    = idx_q;
                end else if (idx_q == LAST_IDX) begin
                    serial_d = 1'b0;
                    idx_d    = {IDX_W{1'b0}};
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = GAP_W'(GAP_LOAD);
                    end
                end else begin
                    // Counter only advances below LAST_IDX, so it saturates there.
                    idx_d      = idx_q + 1'b1;
                    serial_d   = pick_bit(shadow_q, idx_q + 1'b1);
                    shift_en_d = 1'b1;
                    done_d     = ((idx_q + 1'b1) == LAST_IDX);
                end
            end
            ST_GAP: begin
                serial_d = 1'b0;
                if (gap_q == {GAP_W{1'b0}}) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                shadow_d = {DATA_W{1'b0}};
                idx_d    = {IDX_W{1'b0}};
                gap_d    = {GAP_W{1'b0}};
                ready_d  = 1'b1;
                serial_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shadow_q   <= {DATA_W{1'b0}};
            idx_q      <= {IDX_W{1'b0}};
            gap_q      <= {GAP_W{1'b0}};
            ready_q    <= 1'b1;
            serial_q   <= 1'b0;
            shift_en_q <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            ready_q    <= ready_d;
            serial_q   <= serial_d;
            shift_en_q <= shift_en_d;
            start_q    <= start_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ready    = ready_q;
    assign serial_out  = serial_q;
    assign shift_en    = shift_en_q;
    assign frame_start = start_q;
    assign frame_done  = done_q;
    assign busy        = busy_q;
    assign bit_idx     = idx_q;

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencer that feeds a serial shift datapath. It accepts parallel words over a valid/ready handshake and presents them one bit per clock, with a per-bit shift strobe for the downstream shift register. It brackets each frame with start/done pulses and inserts a programmable idle gap between frames. It sits between a parallel producer and the serial shift register chain.

Parameters:
DATA_W, 8, width of a parallel word (>=2)
GAP_CYCLES, 1, idle cycles inserted after each frame (0 allowed)
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  producer has a word
in_data  input  DATA_W  parallel word to serialise
in_ready  output  1  controller can accept a word (high only in IDLE)
hold  input  1  pause request; freezes shifting while high
serial_out  output  1  current serial bit
shift_en  output  1  strobe: downstream register shifts serial_out in this cycle
frame_start  output  1  one-cycle pulse with the first bit of a frame
frame_done  output  1  one-cycle pulse with the last bit of a frame
busy  output  1  high in SHIFT or GAP
bit_idx  output  $clog2(DATA_W+1)  index of the bit currently presented

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset).
- All outputs are registered.
- Reset values: state=IDLE, in_ready=1, serial_out=0, shift_en=0, frame_start=0, frame_done=0, busy=0, bit_idx=0, shadow word=0.
- States:
  - IDLE: in_ready=1. If in_valid is high at an edge, capture in_data into the shadow register and go to SHIFT.
  - SHIFT: one bit per non-held cycle.
  - GAP: counts GAP_CYCLES, then returns to IDLE.
- Latency:
  - Word accepted at edge T. First bit is on serial_out with shift_en=1, frame_start=1 and bit_idx=0 during cycle T+1.
  - Bit k appears at T+1+k when there is no hold.
- Bit order: MSB_FIRST=1 presents in_data[DATA_W-1-k] at index k. MSB_FIRST=0 presents in_data[k].
- hold:
  - Sampled each cycle in SHIFT. hold=1 at an edge means the bit does not advance: serial_out and bit_idx keep their values and shift_en=0 for the next cycle.
  - frame_start fires only once per frame, even if the first bit is held.
  - hold is ignored in IDLE and GAP.
- Last bit: frame_done=1 in the cycle the last bit is presented with shift_en=1. The next state is GAP, or IDLE if GAP_CYCLES=0.
- GAP: serial_out=0, shift_en=0, busy=1 for exactly GAP_CYCLES cycles. in_ready stays 0.
- Throughput: one frame per DATA_W+GAP_CYCLES+1 cycles without hold. in_ready is low from the accept edge until re-entry to IDLE. No input is accepted mid-frame, and in_data changes mid-frame have no effect.
- Reset mid-frame: the frame is abandoned and all outputs return to reset values at that edge. No frame_done is emitted.
- Simultaneous events:
  - reset wins over everything.
  - in_valid while not in IDLE is ignored; the producer must hold it.
- The bit counter saturates at the frame length; no wrap-around is ever observable.

Optional Feature:
Macro SHIFT_SEQ_PARITY_EN.
- Defined: an even-parity bit (XOR of the shadow word) is appended after the data bits. Frame length becomes DATA_W+1, bit_idx reaches DATA_W, and frame_done moves to the parity bit. hold applies to the parity bit too.
- Undefined: frames are DATA_W bits, with no parity logic or counter extension.

Test Plan:
1. DATA_W=8, MSB_FIRST=1, GAP=1; accept 0xA5 at T -> serial_out 1,0,1,0,0,1,0,1 at T+1..T+8 with shift_en=1; frame_start at T+1; frame_done at T+8; GAP at T+9; in_ready=1 at T+10.
2. Same word with hold=1 for 3 cycles after bit 2 -> bit 2 value (1) stays on serial_out with shift_en=0 for 3 cycles; frame_done delays to T+11; exactly 8 shift_en pulses in total.
3. in_valid held high with 0x0F then 0xF0, GAP=0 -> second word accepted at T+9; frames contiguous except one IDLE cycle; MSB_FIRST=0 on 0x0F gives 1,1,1,1,0,0,0,0.
4. Assert reset at T+4 mid-frame -> next cycle: busy=0, shift_en=0, serial_out=0, in_ready=1, no frame_done; a new word is accepted normally afterwards.
5. SHIFT_SEQ_PARITY_EN defined: 0xA5 -> parity bit 0 at T+9 with frame_done; 0x07 -> parity bit 1; bit_idx=8 on the parity bit.
6. in_valid asserted during GAP and SHIFT -> ignored (in_ready=0); word is accepted only on the first IDLE cycle.
